// File: rtl/bcd_pkg.sv
// Shared defaults, FSM state type and iteration-counter sizing for the
// scheduled binary-to-BCD converter.
package bcd_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int DIGITS_DEF = 4;
  localparam int CNT_W_DEF  = $clog2(DATA_W_DEF + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction
endpackage

// File: rtl/bcd_dd_core.sv
// Iterative double-dabble datapath: one add-3/shift step per cycle while
// step is high; last flags the step that completes DATA_W shifts.
module bcd_dd_core
  import bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_W-1:0]     bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  last
);
  localparam int CW = cnt_w(DATA_W);

  logic [DATA_W-1:0]   sh;
  logic [DIGITS*4-1:0] acc, adj;
  logic [CW-1:0]       cnt;

  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++)
      if (acc[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= bin;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      {acc, sh} <= {adj, sh} << 1;
      cnt       <= cnt + 1'b1;
    end
  end

  assign bcd  = acc;
  assign last = (cnt == CW'(DATA_W - 1));
endmodule

// File: rtl/bcd_conv_sched.sv
// Two-channel round-robin front end sharing one double-dabble converter;
// holds the FSM, arbiter and per-channel result registers.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ch0_valid,
  input  logic [DATA_W-1:0]   ch0_data,
  output logic                ch0_ready,
  input  logic                ch1_valid,
  input  logic [DATA_W-1:0]   ch1_data,
  output logic                ch1_ready,
  output logic [DIGITS*4-1:0] ch0_bcd,
  output logic [DIGITS*4-1:0] ch1_bcd,
  output logic                ch0_done,
  output logic                ch1_done,
  output logic                busy
);
  state_t              state, nxt;
  logic                last_srv, gnt;
  logic                win0, win1, load, step, last;
  logic [DIGITS*4-1:0] res;

  bcd_dd_core #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .bin   (ch1_ready ? ch1_data : ch0_data),
    .bcd   (res),
    .last  (last)
  );

  // last_srv = 1 means channel 1 was served last, so channel 0 wins a tie.
  always_comb begin
    win0      = ch0_valid & (~ch1_valid | last_srv);
    win1      = ch1_valid & (~ch0_valid | ~last_srv);
    ch0_ready = (state == IDLE) & win0;
    ch1_ready = (state == IDLE) & win1;
    nxt       = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (ch0_ready | ch1_ready) begin
        load = 1'b1;
        nxt  = CONV;
      end
      CONV: begin
        step = 1'b1;
        if (last) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_srv <= 1'b1;
      ch0_bcd  <= '0;
      ch1_bcd  <= '0;
      ch0_done <= 1'b0;
      ch1_done <= 1'b0;
    end else begin
      state    <= nxt;
      ch0_done <= 1'b0;
      ch1_done <= 1'b0;
      if (load) gnt <= ch1_ready;
      if (state == DONE) begin
        last_srv <= gnt;
        if (gnt) begin
          ch1_bcd  <= res;
          ch1_done <= 1'b1;
        end else begin
          ch0_bcd  <= res;
          ch0_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed plus randomized checks of the two-channel BCD converter against
// a decimal-arithmetic reference with a round-robin grant model.
module tb_bcd_conv_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [11:0] ch0_data = '0, ch1_data = '0;
  logic        ch0_ready, ch1_ready, ch0_done, ch1_done, busy;
  logic [15:0] ch0_bcd, ch1_bcd;

  int errors = 0;
  int checks = 0;
  int last_m = 1;
  logic [15:0] exp_bcd [2];

  bcd_conv_sched dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
    .ch0_bcd(ch0_bcd), .ch1_bcd(ch1_bcd),
    .ch0_done(ch0_done), .ch1_done(ch1_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the block is idle; leaves the bench at the
  // negedge of the cycle in which the result first appears.
  task automatic xfer(input bit v0, input int d0, input bit v1, input int d1,
                      input bit hold, input bit corrupt);
    int w;
    ch0_valid = v0; ch0_data = 12'(d0);
    ch1_valid = v1; ch1_data = 12'(d1);
    w = (v0 && !v1) ? 0 : (v1 && !v0) ? 1 : (last_m == 1) ? 0 : 1;
    #1;
    chk("busy_idle", busy, 0);
    chk("ready0", ch0_ready, w == 0);
    chk("ready1", ch1_ready, w == 1);
    @(posedge clk); #1;
    if (!hold) begin ch0_valid = 0; ch1_valid = 0; end
    if (corrupt) begin ch0_data = 12'd7; ch1_data = 12'd7; end
    exp_bcd[w] = to_bcd(w ? d1 : d0);
    last_m = w;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); @(negedge clk);
      chk("done0", ch0_done, (k == 13) && (w == 0));
      chk("done1", ch1_done, (k == 13) && (w == 1));
      if (k < 13) begin
        chk("busy_conv", busy, 1);
        chk("ready_conv", {ch0_ready, ch1_ready}, 0);
      end
    end
    chk("bcd0", ch0_bcd, exp_bcd[0]);
    chk("bcd1", ch1_bcd, exp_bcd[1]);
  endtask

  initial begin
    exp_bcd[0] = '0; exp_bcd[1] = '0;
    #2;
    chk("rst_bcd0", ch0_bcd, 0);
    chk("rst_bcd1", ch1_bcd, 0);
    chk("rst_done", {ch0_done, ch1_done}, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single channel, then held pair, then another pair
    xfer(1, 412, 0, 0, 0, 0);
    xfer(1, 412, 1, 3123, 1, 0);
    xfer(1, 412, 1, 3123, 1, 0);
    xfer(1, 55, 1, 678, 1, 0);
    xfer(1, 55, 1, 678, 1, 0);
    ch0_valid = 0; ch1_valid = 0;

    // boundaries and mid-conversion data change
    xfer(1, 0, 0, 0, 0, 0);
    xfer(0, 0, 1, 4095, 0, 0);
    xfer(1, 999, 0, 0, 0, 0);
    xfer(0, 0, 1, 1000, 0, 0);
    xfer(1, 412, 0, 0, 0, 1);

    for (int i = 0; i < 24; i++) begin
      int s = $urandom_range(1, 3);
      xfer(s[0], $urandom_range(0, 4095), s[1], $urandom_range(0, 4095),
           $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // reset in the middle of a conversion
    ch0_valid = 1; ch0_data = 12'd1234; ch1_valid = 0;
    @(posedge clk); #1;
    ch0_valid = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_bcd0", ch0_bcd, 0);
    chk("arst_bcd1", ch1_bcd, 0);
    chk("arst_busy", busy, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("arst_done", {ch0_done, ch1_done}, 0);
    end
    rst_n = 1'b1;
    exp_bcd[0] = '0; exp_bcd[1] = '0; last_m = 1;
    @(negedge clk);
    xfer(0, 0, 1, 2048, 0, 0);
    xfer(1, 321, 1, 9, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
